// File: rtl/spi_master_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_master_burst                                             |
// | Description : SPI master, runtime CPOL/CPHA, decoded slave selects and     |
// |               multi-word bursts with slave select held between words.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module spi_master_burst #(
    parameter int DIV_LOG2   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SS     = 2,
    parameter int SS_SEL_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [SS_SEL_W-1:0]   ss_sel,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  new_data,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SS-1:0]     ss_n
);

    localparam int c_HALF  = 2 ** (DIV_LOG2 - 1);
    localparam int c_CNT_W = DIV_LOG2;
    localparam int c_BIT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_LEAD     = 3'd1;
    localparam logic [2:0] c_ST_TRANSFER = 3'd2;
    localparam logic [2:0] c_ST_HOLD     = 3'd3;
    localparam logic [2:0] c_ST_TRAIL    = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_phase;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_hold;

    logic                  r_sck;
    logic                  r_mosi;
    logic [NUM_SS-1:0]     r_ss_n;
    logic                  r_busy;
    logic                  r_new_data;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_sck_nxt;
    logic                  w_mosi_nxt;
    logic [NUM_SS-1:0]     w_ss_n_nxt;
    logic                  w_busy_nxt;
    logic                  w_new_data_nxt;
    logic [DATA_WIDTH-1:0] w_data_out_nxt;

    logic                  w_half_done;
    logic                  w_last_bit;
    logic                  w_accept;
    logic                  w_from_idle;
    logic                  w_cpol_eff;
    logic                  w_cpha_eff;
    logic                  w_lead_evt;
    logic                  w_trail_evt;
    logic                  w_done;
    logic                  w_sample;
    logic                  w_drive;
    logic [NUM_SS-1:0]     w_ss_dec;

    assign w_half_done = (r_cnt == c_HALF_LAST);
    assign w_last_bit  = (r_bit == c_BIT_LAST);
    assign w_from_idle = start && (r_state == c_ST_IDLE);
    assign w_accept    = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_HOLD));
    // Mode is only taken from the pins when a burst opens; HOLD keeps the burst's mode.
    assign w_cpol_eff  = w_from_idle ? cpol : r_cpol;
    assign w_cpha_eff  = w_from_idle ? cpha : r_cpha;

    assign w_lead_evt  = ((r_state == c_ST_LEAD) && w_half_done) ||
                         ((r_state == c_ST_TRANSFER) && r_phase && w_half_done && !w_last_bit);
    assign w_trail_evt = (r_state == c_ST_TRANSFER) && !r_phase && w_half_done;
    assign w_done      = (r_state == c_ST_TRANSFER) && r_phase && w_half_done && w_last_bit;
    assign w_sample    = r_cpha ? w_trail_evt : w_lead_evt;
    assign w_drive     = r_cpha ? w_lead_evt : (w_trail_evt && !w_last_bit);

    // Out-of-range selects match no line, so the word runs with every ss_n high.
    generate
        for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
            assign w_ss_dec[gi] = (ss_sel == SS_SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:     if (start) w_state_nxt = c_ST_LEAD;
            c_ST_LEAD:     if (w_half_done) w_state_nxt = c_ST_TRANSFER;
            c_ST_TRANSFER: if (w_done) w_state_nxt = r_hold ? c_ST_HOLD : c_ST_TRAIL;
            c_ST_HOLD: begin
                if (start) begin
                    w_state_nxt = c_ST_LEAD;
                end else if (!hold) begin
                    w_state_nxt = c_ST_TRAIL;
                end
            end
            c_ST_TRAIL:    if (w_half_done) w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_sck_nxt      = r_sck;
        w_mosi_nxt     = r_mosi;
        w_ss_n_nxt     = r_ss_n;
        w_new_data_nxt = 1'b0;
        w_data_out_nxt = r_data_out;
        w_busy_nxt     = (w_state_nxt == c_ST_LEAD) || (w_state_nxt == c_ST_TRANSFER) ||
                         (w_state_nxt == c_ST_TRAIL);
        if (w_accept) begin
            w_sck_nxt = w_cpol_eff;
            if (!w_cpha_eff) begin
                w_mosi_nxt = data_in[DATA_WIDTH-1];
            end
            if (w_from_idle) begin
                w_ss_n_nxt = ~w_ss_dec;
            end
        end
        if (w_lead_evt) begin
            w_sck_nxt = ~r_cpol;
        end
        if (w_trail_evt) begin
            w_sck_nxt = r_cpol;
        end
        if (w_drive) begin
            w_mosi_nxt = r_tx[DATA_WIDTH-1];
        end
        if (w_done) begin
            w_new_data_nxt = 1'b1;
            w_data_out_nxt = r_rx;
        end
        if ((r_state == c_ST_TRAIL) && w_half_done) begin
            w_ss_n_nxt = '1;
            w_mosi_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
            r_ss_n     <= '1;
            r_busy     <= 1'b0;
            r_new_data <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_sck      <= w_sck_nxt;
            r_mosi     <= w_mosi_nxt;
            r_ss_n     <= w_ss_n_nxt;
            r_busy     <= w_busy_nxt;
            r_new_data <= w_new_data_nxt;
            r_data_out <= w_data_out_nxt;
        end
    end

    // Timing and shift datapath; r_tx is pre-shifted in mode cpha=0 because the MSB leaves at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            if (w_half_done || (w_state_nxt != r_state) ||
                (r_state == c_ST_IDLE) || (r_state == c_ST_HOLD)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (r_state != c_ST_TRANSFER) begin
                r_phase <= 1'b0;
                r_bit   <= '0;
            end else if (w_half_done) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_bit <= r_bit + c_BIT_W'(1);
                end
            end

            if (w_accept) begin
                r_tx   <= w_cpha_eff ? data_in : {data_in[DATA_WIDTH-2:0], 1'b0};
                r_hold <= hold;
                if (w_from_idle) begin
                    r_cpol <= cpol;
                    r_cpha <= cpha;
                end
            end else if (w_drive) begin
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_sample) begin
                r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
            end
        end
    end

    assign sck      = r_sck;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;
    assign busy     = r_busy;
    assign new_data = r_new_data;
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_burst                                          |
// | Description : Directed bench for spi_master_burst with a mode-aware slave. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_spi_master_burst;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic [0:0] ss_sel = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       new_data;
    logic       busy;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [1:0] ss_n;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat;
    int nd_pulses = 0;
    int ss1_rises = 0;
    int ss0_low_cnt = 0;
    int b_nd, b_ss1, b_ss0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] slv_q[$];

    logic       sl_cpol = 1'b0;
    logic       sl_cpha = 1'b0;
    logic [7:0] s_tx, s_rx, e_rx, e_tx;
    int         s_edges = 0;
    logic       prev_busy = 1'b0, prev_sck = 1'b0, prev_nd = 1'b0, prev_ss1 = 1'b1;

    spi_master_burst #(
        .DIV_LOG2   (2),
        .DATA_WIDTH (8),
        .NUM_SS     (2),
        .SS_SEL_W   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cpol     (cpol),
        .cpha     (cpha),
        .ss_sel   (ss_sel),
        .hold     (hold),
        .data_in  (data_in),
        .data_out (data_out),
        .new_data (new_data),
        .busy     (busy),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .ss_n     (ss_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave and scoreboard: sampled on the falling clk edge, half a cycle clear of DUT updates.
    always @(negedge clk) begin
        if (rst) begin
            miso      = 1'b0;
            prev_busy = 1'b0;
            prev_sck  = 1'b0;
            prev_nd   = 1'b0;
            prev_ss1  = 1'b1;
        end else begin
            if (new_data) begin
                nd_pulses++;
                check("nd_one_cycle", prev_nd, 1'b0);
                check("sb_nonempty", 32'(exp_rx_q.size() > 0), 1);
                if (exp_rx_q.size() > 0) begin
                    e_rx = exp_rx_q.pop_front();
                    e_tx = exp_tx_q.pop_front();
                    check("data_out", data_out, e_rx);
                    check("mosi_word", s_rx, e_tx);
                    check("sck_edges", s_edges, 16);
                end
            end
            if (!ss_n[0]) ss0_low_cnt++;
            if (ss_n[1] && !prev_ss1) ss1_rises++;
            if (busy && !prev_busy) begin
                s_tx    = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
                s_rx    = 8'h00;
                s_edges = 0;
                if (!sl_cpha) begin
                    miso = s_tx[7];
                    s_tx = {s_tx[6:0], 1'b0};
                end
            end else if (busy && prev_busy && (sck !== prev_sck)) begin
                s_edges++;
                if ((sck !== sl_cpol) != sl_cpha) begin
                    s_rx = {s_rx[6:0], mosi};
                end else begin
                    miso = s_tx[7];
                    s_tx = {s_tx[6:0], 1'b0};
                end
            end
            prev_busy = busy;
            prev_sck  = sck;
            prev_nd   = new_data;
            prev_ss1  = ss_n[1];
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Called on a falling edge; returns on the falling edge of cycle 1 (first LEAD cycle).
    task automatic start_word(input logic [7:0] d, input logic [7:0] sw, input logic h);
        exp_rx_q.push_back(sw);
        exp_tx_q.push_back(d);
        slv_q.push_back(sw);
        data_in = d;
        hold    = h;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_nd(output int l);
        while (!new_data && cyc < 100) tick();
        check("nd_seen", new_data, 1'b1);
        l = cyc;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b1);
        check("rst_ss_n", ss_n, 2'b11);
        check("rst_busy", busy, 1'b0);
        check("rst_new_data", new_data, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0 single word
        start_word(8'hA5, 8'h3C, 1'b0);
        check("t1_lead_ss", ss_n, 2'b10);
        check("t1_lead_mosi", mosi, 1'b1);
        check("t1_lead_busy", busy, 1'b1);
        check("t1_lead_sck", sck, 1'b0);
        wait_nd(lat);
        check("t1_latency", lat, 35);
        check("t1_ss_at_nd", ss_n, 2'b10);
        tick();
        check("t1_trail2_ss", ss_n, 2'b10);
        check("t1_trail2_busy", busy, 1'b1);
        tick();
        check("t1_idle_ss", ss_n, 2'b11);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_mosi", mosi, 1'b1);

        // All four modes
        for (int m = 0; m < 4; m++) begin
            cpol    = m[1];
            cpha    = m[0];
            sl_cpol = m[1];
            sl_cpha = m[0];
            start_word(8'h81, 8'h7E, 1'b0);
            check("t2_lead_sck", sck, cpol);
            tick();
            tick();
            check("t2_first_edge", sck, !cpol);
            wait_nd(lat);
            check("t2_latency", lat, 35);
            repeat (3) tick();
            check("t2_idle_sck", sck, cpol);
            check("t2_idle_ss", ss_n, 2'b11);
        end
        cpol = 1'b0; cpha = 1'b0; sl_cpol = 1'b0; sl_cpha = 1'b0;

        // Three-word burst on slave 1
        b_nd = nd_pulses; b_ss1 = ss1_rises; b_ss0 = ss0_low_cnt;
        ss_sel = 1'b1;
        start_word(8'h11, 8'hC3, 1'b1);
        check("t3_ss_sel1", ss_n, 2'b01);
        wait_nd(lat);
        check("t3_lat_w0", lat, 35);
        check("t3_hold_busy", busy, 1'b0);
        ss_sel = 1'b0;
        tick();
        check("t3_hold_ss", ss_n, 2'b01);
        start_word(8'h22, 8'h5A, 1'b1);
        wait_nd(lat);
        check("t3_lat_w1", lat, 35);
        start_word(8'h33, 8'h96, 1'b0);
        wait_nd(lat);
        check("t3_lat_w2", lat, 35);
        repeat (3) tick();
        check("t3_nd_count", nd_pulses - b_nd, 3);
        check("t3_ss1_rises", ss1_rises - b_ss1, 1);
        check("t3_ss0_never", ss0_low_cnt - b_ss0, 0);
        check("t3_idle_ss", ss_n, 2'b11);

        // HOLD exits: start beats hold=0, then plain hold=0
        start_word(8'h5A, 8'hA5, 1'b1);
        wait_nd(lat);
        start_word(8'h3C, 8'h0F, 1'b0);
        check("t4_start_wins", busy, 1'b1);
        wait_nd(lat);
        check("t4_lat", lat, 35);
        tick();
        tick();
        check("t4_idle_ss", ss_n, 2'b11);
        check("t4_idle_busy", busy, 1'b0);
        start_word(8'h77, 8'h88, 1'b1);
        wait_nd(lat);
        repeat (3) tick();
        check("t4_hold_busy", busy, 1'b0);
        check("t4_hold_ss", ss_n, 2'b10);
        hold = 1'b0;
        tick();
        check("t4_trail_busy", busy, 1'b1);
        check("t4_trail_ss", ss_n, 2'b10);
        tick();
        tick();
        check("t4_end_busy", busy, 1'b0);
        check("t4_end_ss", ss_n, 2'b11);

        // start and cpol changes while busy are ignored
        b_nd = nd_pulses;
        start_word(8'hC6, 8'h39, 1'b1);
        repeat (8) tick();
        start = 1'b1; cpol = 1'b1; data_in = 8'hFF;
        repeat (3) tick();
        start = 1'b0;
        wait_nd(lat);
        check("t5_lat", lat, 35);
        start_word(8'hE1, 8'h1E, 1'b0);
        check("t5_lead_sck", sck, 1'b0);
        tick();
        tick();
        check("t5_first_edge", sck, 1'b1);
        wait_nd(lat);
        check("t5_lat2", lat, 35);
        repeat (3) tick();
        check("t5_idle_sck", sck, 1'b0);
        check("t5_nd_count", nd_pulses - b_nd, 2);
        cpol = 1'b0;

        // Reset mid-word
        b_nd = nd_pulses;
        start_word(8'h99, 8'h66, 1'b0);
        repeat (11) tick();
        rst = 1'b1;
        #1;
        check("t6_sck", sck, 1'b0);
        check("t6_mosi", mosi, 1'b1);
        check("t6_ss_n", ss_n, 2'b11);
        check("t6_busy", busy, 1'b0);
        check("t6_new_data", new_data, 1'b0);
        check("t6_data_out", data_out, 8'h00);
        exp_rx_q.delete();
        exp_tx_q.delete();
        slv_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("t6_no_nd", nd_pulses - b_nd, 0);
        start_word(8'hE7, 8'h18, 1'b0);
        wait_nd(lat);
        check("t6_lat", lat, 35);
        repeat (3) tick();
        check("t6_nd_count", nd_pulses - b_nd, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
